// File: rtl/contador_regressivo_bcd.sv
// BCD MM:SS countdown timer with a 1-tick prescaler and an IDLE/RUN/PAUSE/DONE control FSM.
// Each stage borrows from the next higher stage, so the count stops cleanly at 00:00.
module contador_regressivo_bcd #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] preset_mt,
    input  logic [3:0] preset_mu,
    input  logic [3:0] preset_st,
    input  logic [3:0] preset_su,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [PW-1:0] presc_r;
    logic [3:0]  min_t_r, min_u_r, sec_t_r, sec_u_r;
    logic        running_r, done_r, done_pulse_r;

    logic [3:0]  dec_mt_s, dec_mu_s, dec_st_s, dec_su_s;
    logic        count_zero_s, count_one_s, tick_s;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] clamp5(input logic [3:0] d);
        return (d > 4'd5) ? 4'd5 : d;
    endfunction

    // Borrow chain: value the digits take on the next tick.
    always_comb begin
        dec_mt_s = min_t_r;
        dec_mu_s = min_u_r;
        dec_st_s = sec_t_r;
        dec_su_s = sec_u_r;
        if (sec_u_r == 4'd0) begin
            dec_su_s = 4'd9;
            if (sec_t_r == 4'd0) begin
                dec_st_s = 4'd5;
                if (min_u_r == 4'd0) begin
                    dec_mu_s = 4'd9;
                    dec_mt_s = min_t_r - 4'd1;
                end else begin
                    dec_mu_s = min_u_r - 4'd1;
                end
            end else begin
                dec_st_s = sec_t_r - 4'd1;
            end
        end else begin
            dec_su_s = sec_u_r - 4'd1;
        end
    end

    // Status flags on the current count and prescaler.
    always_comb begin
        count_zero_s = (min_t_r == 4'd0) && (min_u_r == 4'd0) &&
                       (sec_t_r == 4'd0) && (sec_u_r == 4'd0);
        count_one_s  = (min_t_r == 4'd0) && (min_u_r == 4'd0) &&
                       (sec_t_r == 4'd0) && (sec_u_r == 4'd1);
        tick_s       = (presc_r == TICK_LAST);
    end

    // Control FSM, prescaler and digit registers; priority reset > load > start_stop > tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            presc_r      <= '0;
            min_t_r      <= 4'd0;
            min_u_r      <= 4'd0;
            sec_t_r      <= 4'd0;
            sec_u_r      <= 4'd0;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
            done_pulse_r <= 1'b0;
        end else begin
            done_pulse_r <= 1'b0;
            if (load) begin
                min_t_r   <= clamp9(preset_mt);
                min_u_r   <= clamp9(preset_mu);
                sec_t_r   <= clamp5(preset_st);
                sec_u_r   <= clamp9(preset_su);
                state_r   <= IDLE;
                presc_r   <= '0;
                running_r <= 1'b0;
                done_r    <= 1'b0;
            end else if (start_stop) begin
                case (state_r)
                    IDLE: begin
                        if (!count_zero_s) begin
                            state_r   <= RUN;
                            running_r <= 1'b1;
                            presc_r   <= '0;
                        end
                    end
                    RUN: begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end
                    PAUSE: begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                        presc_r   <= '0;
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end else if (state_r == RUN) begin
                if (tick_s) begin
                    presc_r <= '0;
                    min_t_r <= dec_mt_s;
                    min_u_r <= dec_mu_s;
                    sec_t_r <= dec_st_s;
                    sec_u_r <= dec_su_s;
                    if (count_one_s) begin
                        state_r      <= DONE;
                        running_r    <= 1'b0;
                        done_r       <= 1'b1;
                        done_pulse_r <= 1'b1;
                    end
                end else begin
                    presc_r <= presc_r + PW'(1);
                end
            end
        end
    end

    assign min_t      = min_t_r;
    assign min_u      = min_u_r;
    assign sec_t      = sec_t_r;
    assign sec_u      = sec_u_r;
    assign running    = running_r;
    assign done       = done_r;
    assign done_pulse = done_pulse_r;

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// Directed bench for the BCD countdown timer: a seconds-based reference model checked every
// cycle, plus hand-computed literal checkpoints along the stimulus sequence.
module tb_contador_regressivo_bcd;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       start_stop = 1'b0;
    logic [3:0] preset_mt = 4'd0, preset_mu = 4'd0, preset_st = 4'd0, preset_su = 4'd0;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, done, done_pulse;

    int total = 0;
    int bad   = 0;

    contador_regressivo_bcd #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .load(load), .start_stop(start_stop),
        .preset_mt(preset_mt), .preset_mu(preset_mu),
        .preset_st(preset_st), .preset_su(preset_su),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .running(running), .done(done), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time in seconds, mode, and cycles spent running since (re)start.
    int m_secs  = 0;
    int m_mode  = 0;   // 0 idle, 1 run, 2 pause, 3 done
    int m_cyc   = 0;
    bit m_pulse = 1'b0;
    bit m_valid = 1'b0;

    function automatic int sat(input logic [3:0] d, input int lim);
        return (int'(d) > lim) ? lim : int'(d);
    endfunction

    always @(posedge clk) begin
        m_pulse = 1'b0;
        if (!reset) begin
            m_secs = 0; m_mode = 0; m_cyc = 0; m_valid = 1'b1;
        end else if (load) begin
            m_secs = (sat(preset_mt, 9) * 10 + sat(preset_mu, 9)) * 60
                   + sat(preset_st, 5) * 10 + sat(preset_su, 9);
            m_mode = 0; m_cyc = 0;
        end else if (start_stop) begin
            if (m_mode == 0 && m_secs != 0) begin m_mode = 1; m_cyc = 0; end
            else if (m_mode == 1) m_mode = 2;
            else if (m_mode == 2) begin m_mode = 1; m_cyc = 0; end
        end else if (m_mode == 1) begin
            m_cyc++;
            if (m_cyc == TD) begin
                m_cyc = 0;
                m_secs--;
                if (m_secs == 0) begin m_mode = 3; m_pulse = 1'b1; end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [18:0] exp_v, got_v;
        int mm, ss;
        if (m_valid) begin
            mm = m_secs / 60;
            ss = m_secs % 60;
            exp_v = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                     (m_mode == 1), (m_mode == 3), m_pulse};
            got_v = {min_t, min_u, sec_t, sec_u, running, done, done_pulse};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL model t=%0t got=%h run/done/pulse=%b%b%b required=%h run/done/pulse=%b%b%b",
                         $time, got_v[18:3], got_v[2], got_v[1], got_v[0],
                         exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    function automatic logic [18:0] pack(input logic [15:0] d, input logic r, input logic dn, input logic p);
        return {d, r, dn, p};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        preset_mt = a; preset_mu = b; preset_st = c; preset_su = d;
        load = 1'b1; cyc(1); load = 1'b0;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    endtask

    logic [18:0] now_v;
    always_comb now_v = {min_t, min_u, sec_t, sec_u, running, done, done_pulse};

    initial begin
        // 1: reset and start at 00:00
        reset = 1'b0; cyc(2);
        chk("reset_state", now_v, pack(16'h0000, 1'b0, 1'b0, 1'b0));
        reset = 1'b1; cyc(1);
        pulse_ss();
        chk("start_at_zero", now_v, pack(16'h0000, 1'b0, 1'b0, 1'b0));

        // 2: 00:12 to done
        do_load(4'd0, 4'd0, 4'd1, 4'd2);
        pulse_ss();
        cyc(3);
        chk("before_first_tick", now_v, pack(16'h0012, 1'b1, 1'b0, 1'b0));
        cyc(1);
        chk("first_tick", now_v, pack(16'h0011, 1'b1, 1'b0, 1'b0));
        cyc(8);
        chk("borrow_10_to_09", now_v, pack(16'h0009, 1'b1, 1'b0, 1'b0));
        cyc(35);
        chk("at_00_01", now_v, pack(16'h0001, 1'b1, 1'b0, 1'b0));
        cyc(1);
        chk("done_entry", now_v, pack(16'h0000, 1'b0, 1'b1, 1'b1));
        cyc(1);
        chk("done_hold", now_v, pack(16'h0000, 1'b0, 1'b1, 1'b0));

        // 3: minute borrows
        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        pulse_ss(); cyc(4);
        chk("10_00_to_09_59", now_v, pack(16'h0959, 1'b1, 1'b0, 1'b0));
        do_load(4'd0, 4'd1, 4'd0, 4'd0);
        pulse_ss(); cyc(4);
        chk("01_00_to_00_59", now_v, pack(16'h0059, 1'b1, 1'b0, 1'b0));

        // 4: pause / resume
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        pulse_ss(); cyc(5);
        pulse_ss();
        cyc(20);
        chk("paused_hold", now_v, pack(16'h0004, 1'b0, 1'b0, 1'b0));
        pulse_ss(); cyc(3);
        chk("resume_3", now_v, pack(16'h0004, 1'b1, 1'b0, 1'b0));
        cyc(1);
        chk("resume_4", now_v, pack(16'h0003, 1'b1, 1'b0, 1'b0));

        // 5: sanitising and load+start_stop collision
        do_load(4'hF, 4'hA, 4'd7, 4'hC);
        chk("sanitise", now_v, pack(16'h9959, 1'b0, 1'b0, 1'b0));
        pulse_ss(); cyc(2);
        load = 1'b1; start_stop = 1'b1; cyc(1); load = 1'b0; start_stop = 1'b0;
        chk("load_beats_ss", now_v, pack(16'h9959, 1'b0, 1'b0, 1'b0));
        cyc(4);
        chk("load_beats_ss_idle", now_v, pack(16'h9959, 1'b0, 1'b0, 1'b0));

        // 6: reset mid-run, DONE ignores start_stop, load exits DONE
        do_load(4'd0, 4'd0, 4'd4, 4'd5);
        pulse_ss(); cyc(60);
        chk("at_00_30", now_v, pack(16'h0030, 1'b1, 1'b0, 1'b0));
        cyc(2);
        reset = 1'b0; cyc(1); reset = 1'b1;
        chk("reset_mid_run", now_v, pack(16'h0000, 1'b0, 1'b0, 1'b0));
        cyc(5);
        chk("reset_stays_idle", now_v, pack(16'h0000, 1'b0, 1'b0, 1'b0));
        do_load(4'd0, 4'd0, 4'd0, 4'd1);
        pulse_ss(); cyc(4);
        chk("short_done", now_v, pack(16'h0000, 1'b0, 1'b1, 1'b1));
        pulse_ss(); cyc(6);
        chk("done_ignores_ss", now_v, pack(16'h0000, 1'b0, 1'b1, 1'b0));
        do_load(4'd0, 4'd0, 4'd0, 4'd7);
        chk("load_exits_done", now_v, pack(16'h0007, 1'b0, 1'b0, 1'b0));
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
